display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Sequences the 2s-complement decoder datapath (top_decoder) onto a 4-digit
//  multiplexed 7-segment display. Captures a number via valid/ready and drives
//  the decoder input. Time-multiplexes sign/hundreds/tens/units onto one shared
//  segment bus with a refresh prescaler and per-slot ghost blanking.
// PARAMETERS
//  DW_IN         8      width of signed input number (matches decoder DW_IN)
//  REFRESH_DIV   50000  clk cycles per digit slot (>= 2)
//  BLANK_CYCLES  2      cycles at start of each slot with digit_en=0; < REFRESH_DIV
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  disp_en       in   1      display enable; low blanks digits, holds number
//  load_valid    in   1      new number offered
//  load_ready    out  1      block accepts number this cycle
//  load_number   in   DW_IN  signed number to display
//  dec_number    out  DW_IN  registered number driven to decoder .number
//  dec_sign      in   1      decoder sign
//  dec_hundreds  in   7      decoder hundreds segments {g,f,e,d,c,b,a}, active-high
//  dec_tens      in   7      decoder tens segments
//  dec_units     in   7      decoder units segments
//  seg_out       out  7      shared segment bus, active-high
//  digit_en      out  4      one-hot digit select: [3]=sign [2]=hund [1]=tens [0]=units
//  frame_done    out  1      1-cycle pulse when all 4 slots have been shown
// BEHAVIOUR
//  - Reset (async, rst_n=0): dec_number=0, seg_out=0, digit_en=0, frame_done=0,
//    load_ready=1, state=IDLE, prescaler=0, digit index=3.
//  - FSM IDLE -> SETTLE -> SCAN. load_ready=1 in IDLE and SCAN, 0 in SETTLE.
//  - Handshake: transfer on load_valid&&load_ready; dec_number <= load_number
//    that edge; state -> SETTLE (1 cycle, decoder settles, digit_en=0).
//  - SETTLE -> SCAN: prescaler=0, index=3.
//  - SCAN: prescaler counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV); at
//    terminal count wraps to 0 and index decrements 3->2->1->0->3.
//    frame_done pulses the cycle index wraps 0->3.
//  - Slot output (registered, 1-cycle latency from prescaler/index):
//    digit_en = 0 while prescaler < BLANK_CYCLES, else one-hot(index).
//    seg_out: idx3 = dec_sign ? SEG_MINUS : SEG_BLANK; idx2 = dec_hundreds;
//    idx1 = dec_tens; idx0 = dec_units.
//  - Load during SCAN (any slot): accepted, old slot aborted, SETTLE, restart at idx3.
//  - disp_en=0: next edge digit_en=0, seg_out=0, prescaler=0, index=3. Loads are
//    still accepted (IDLE/SETTLE path). disp_en 0->1 with a number loaded -> SCAN at idx3.
//  - Nothing loaded since reset: stay IDLE, digit_en=0.
//  - load_valid and disp_en fall in the same cycle: load wins (number captured),
//    display stays blanked.
// CONFIGURATION
//  `DISP_LZ_BLANK_EN defined: hundreds slot outputs SEG_BLANK when dec_hundreds==SEG_ZERO;
//    tens slot outputs SEG_BLANK when both hundreds and tens ==SEG_ZERO.
//    Units and sign slots are never blanked; digit_en timing is unchanged.
//  Not defined: all digits shown, including leading zeros.
// STRUCTURE
//  Package disp_pkg: SEG_ZERO=7'b0111111, SEG_MINUS=7'b1000000, SEG_BLANK=7'b0,
//    typedef enum logic [1:0] {IDLE,SETTLE,SCAN} scan_state_t, DIGIT_SIGN=2'd3..DIGIT_UNITS=2'd0.
//  One sub-module: scan_prescaler (counter + terminal-count pulse, param REFRESH_DIV).
//  top_decoder remains external; integration wrapper instantiates both.
// TESTING (REFRESH_DIV=4, BLANK_CYCLES=1, real top_decoder attached)
//  1. load -8'sd128, disp_en=1 -> digit_en 0000 (blank), then 1000 MINUS, 0100 '1',
//     0010 '2', 0001 '8'; each one-hot for 3 of 4 cycles; frame_done once per 16 clk.
//  2. load 8'sd5, macro on -> hund/tens seg_out=0, units='5'; macro off -> '0','0','5'.
//  3. load 8'sd42 mid-SCAN at idx1 -> load_ready=0 for 1 cycle, restart idx3 with
//     SEG_BLANK sign, '0', '4', '2'.
//  4. rst_n low mid-slot (async, not clk-aligned) -> all outputs 0 before next clk edge;
//     after release, IDLE with digit_en=0 until a load.
//  5. disp_en low in idx2 -> digit_en=0 next edge; high again -> idx3 first, full frame.
//  6. load_valid held high for 3 cycles at 8'sd127 then -8'sd1 -> last accepted value shown,
//     sign MINUS, '0','0','1'.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared constants and types for the 4-digit multiplexed display scanner.
//   SEG_*        : 7-segment patterns {g,f,e,d,c,b,a}, active-high
//   scan_state_t : scanner FSM states
//   DIGIT_*      : slot indices into the one-hot digit select
//   digit_onehot : converts a slot index into its digit_en pattern
// ---------------------------------------------------------------------------
package disp_pkg;

    localparam logic [6:0] SEG_ZERO  = 7'b0111111;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SCAN   = 2'd2
    } scan_state_t;

    localparam logic [1:0] DIGIT_SIGN     = 2'd3;
    localparam logic [1:0] DIGIT_HUNDREDS = 2'd2;
    localparam logic [1:0] DIGIT_TENS     = 2'd1;
    localparam logic [1:0] DIGIT_UNITS    = 2'd0;

    // Slot index 3 lights digit_en[3] (sign) down to index 0 (units).
    function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl_if
// valid/ready load channel carrying a signed number into the scanner.
//   load_valid  : producer offers load_number
//   load_ready  : scanner accepts this cycle
//   load_number : signed number to display (DW_IN bits)
// Modports: master = number producer, slave = display_scan_ctrl.
// ---------------------------------------------------------------------------
interface display_scan_ctrl_if #(
    parameter int DW_IN = 8
) ();

    logic             load_valid;
    logic             load_ready;
    logic [DW_IN-1:0] load_number;

    modport master (
        output load_valid,
        output load_number,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_number,
        output load_ready
    );

endinterface

// File: rtl/display_scan_ctrl_scan_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
// Free-running slot timer for the display scanner. Counts 0..REFRESH_DIV-1
// while enabled and flags the terminal count so the scanner can advance to
// the next digit.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to 0 (has priority over enable)
//   enable     : advance the count this cycle
//   count      : current position inside the slot
//   terminal   : high on the enabled cycle where count is REFRESH_DIV-1
// ---------------------------------------------------------------------------
module scan_prescaler #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           enable,
    output logic [$clog2(REFRESH_DIV)-1:0] count,
    output logic                           terminal
);

    localparam int            CW   = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign terminal = enable && (count_q == LAST);
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = terminal ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
// Captures a signed number over a valid/ready channel, holds it on the
// external decoder's input, and time-multiplexes the decoder's sign /
// hundreds / tens / units segments onto one shared segment bus. Each slot
// begins with BLANK_CYCLES of digit_en=0 to suppress ghosting.
//   clk, rst_n    : clock, asynchronous active-low reset
//   disp_en       : display enable; low blanks the digits, loads still accepted
//   load_if       : valid/ready number load channel (slave side)
//   dec_number    : registered number driven to the decoder
//   dec_sign/...  : decoder outputs fed back for display
//   seg_out       : shared segment bus, active-high
//   digit_en      : one-hot digit select, [3]=sign .. [0]=units
//   frame_done    : 1-cycle pulse when the units slot hands back to sign
// Build option: define DISP_LZ_BLANK_EN to blank leading-zero hundreds/tens.
// ---------------------------------------------------------------------------
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DW_IN        = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      disp_en,
    display_scan_ctrl_if.slave        load_if,
    output logic [DW_IN-1:0]          dec_number,
    input  logic                      dec_sign,
    input  logic [6:0]                dec_hundreds,
    input  logic [6:0]                dec_tens,
    input  logic [6:0]                dec_units,
    output logic [6:0]                seg_out,
    output logic [3:0]                digit_en,
    output logic                      frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);

    scan_state_t      state_q, state_d;
    logic [DW_IN-1:0] number_q, number_d;
    logic             loaded_q, loaded_d;
    logic [1:0]       index_q, index_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       digit_en_q, digit_en_d;
    logic             frame_done_q, frame_done_d;
    logic             ready_q, ready_d;

    logic             accept;
    logic             scan_run;
    logic [CW-1:0]    presc_cnt;
    logic             presc_tc;
    logic [6:0]       hund_seg;
    logic [6:0]       tens_seg;
    logic [6:0]       slot_seg;

    assign accept   = load_if.load_valid && ready_q;
    // The slot timer only runs while scanning undisturbed; any load or
    // disp_en drop aborts the slot, so the next scan restarts from zero.
    assign scan_run = (state_q == SCAN) && disp_en && !accept;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!scan_run),
        .enable   (scan_run),
        .count    (presc_cnt),
        .terminal (presc_tc)
    );

    // Segment pattern for the slot currently being shown.
    always_comb begin
        hund_seg = dec_hundreds;
        tens_seg = dec_tens;
`ifdef DISP_LZ_BLANK_EN
        // Tens is a leading zero only when hundreds is one as well.
        if (dec_hundreds == SEG_ZERO) begin
            hund_seg = SEG_BLANK;
            if (dec_tens == SEG_ZERO) begin
                tens_seg = SEG_BLANK;
            end
        end
`endif
        case (index_q)
            DIGIT_SIGN:     slot_seg = dec_sign ? SEG_MINUS : SEG_BLANK;
            DIGIT_HUNDREDS: slot_seg = hund_seg;
            DIGIT_TENS:     slot_seg = tens_seg;
            default:        slot_seg = dec_units;
        endcase
    end

    // Next-state and next-output logic. Outputs are zero everywhere except
    // while a scan continues, which gives blanking on load, SETTLE and
    // disp_en=0 for free.
    always_comb begin
        state_d      = state_q;
        number_d     = number_q;
        loaded_d     = loaded_q;
        index_d      = DIGIT_SIGN;
        seg_d        = SEG_BLANK;
        digit_en_d   = '0;
        frame_done_d = 1'b0;

        if (accept) begin
            number_d = load_if.load_number;
            loaded_d = 1'b1;
            state_d  = SETTLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (loaded_q && disp_en) begin
                        state_d = SCAN;
                    end
                end
                SETTLE: begin
                    state_d = disp_en ? SCAN : IDLE;
                end
                SCAN: begin
                    if (!disp_en) begin
                        state_d = IDLE;
                    end else begin
                        seg_d      = slot_seg;
                        digit_en_d = (presc_cnt < CW'(BLANK_CYCLES)) ?
                                     4'b0000 : digit_onehot(index_q);
                        index_d    = presc_tc ? index_q - 2'd1 : index_q;
                        frame_done_d = presc_tc && (index_q == DIGIT_UNITS);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        ready_d = (state_d != SETTLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            number_q     <= '0;
            loaded_q     <= 1'b0;
            index_q      <= DIGIT_SIGN;
            seg_q        <= SEG_BLANK;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            number_q     <= number_d;
            loaded_q     <= loaded_d;
            index_q      <= index_d;
            seg_q        <= seg_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
            ready_q      <= ready_d;
        end
    end

    assign dec_number         = number_q;
    assign seg_out            = seg_q;
    assign digit_en           = digit_en_q;
    assign frame_done         = frame_done_q;
    assign load_if.load_ready = ready_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
`timescale 1ns/1ps
module tb_display_scan_ctrl;

    localparam int DW    = 8;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
`ifdef DISP_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    localparam logic [6:0] S_BL = 7'b0000000;
    localparam logic [6:0] S_MI = 7'b1000000;
    localparam logic [6:0] S_0  = 7'b0111111;
    localparam logic [6:0] S_1  = 7'b0000110;
    localparam logic [6:0] S_2  = 7'b1011011;
    localparam logic [6:0] S_4  = 7'b1100110;
    localparam logic [6:0] S_5  = 7'b1101101;
    localparam logic [6:0] S_7  = 7'b0000111;
    localparam logic [6:0] S_8  = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          disp_en = 1'b0;
    logic [DW-1:0] dec_number;
    logic          dec_sign;
    logic [6:0]    dec_hundreds, dec_tens, dec_units;
    logic [6:0]    seg_out;
    logic [3:0]    digit_en;
    logic          frame_done;
    int            decMag;

    int checks = 0;
    int errors = 0;

    display_scan_ctrl_if #(.DW_IN(DW)) load_if ();

    display_scan_ctrl #(
        .DW_IN        (DW),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .disp_en      (disp_en),
        .load_if      (load_if),
        .dec_number   (dec_number),
        .dec_sign     (dec_sign),
        .dec_hundreds (dec_hundreds),
        .dec_tens     (dec_tens),
        .dec_units    (dec_units),
        .seg_out      (seg_out),
        .digit_en     (digit_en),
        .frame_done   (frame_done)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int magOf(input logic [DW-1:0] n);
        int v;
        v = $signed(n);
        return (v < 0) ? -v : v;
    endfunction

    // Stand-in for the external 2s-complement decoder.
    always_comb begin
        decMag       = magOf(dec_number);
        dec_sign     = dec_number[DW-1];
        dec_hundreds = segOf(decMag / 100);
        dec_tens     = segOf((decMag / 10) % 10);
        dec_units    = segOf(decMag % 10);
    end

    // Expected segment pattern of a slot, from the decimal digits of n.
    function automatic logic [6:0] expSeg(input logic [DW-1:0] n, input int slot);
        int m, h, t, u;
        m = magOf(n);
        h = m / 100;
        t = (m / 10) % 10;
        u = m % 10;
        case (slot)
            3: return n[DW-1] ? S_MI : S_BL;
            2: return (LZ && h == 0) ? S_BL : segOf(h);
            1: return (LZ && h == 0 && t == 0) ? S_BL : segOf(t);
            default: return segOf(u);
        endcase
    endfunction

    // Reference model: phase 0 idle, 1 settle, 2 scanning since edge mT0.
    int            cyc = 0;
    int            mPhase;
    int            mT0;
    bit            mLoaded;
    bit            mReady;
    logic [DW-1:0] mNumber;
    logic [6:0]    eSeg;
    logic [3:0]    eDig;
    logic          eFrame;

    task automatic modelReset();
        mPhase  = 0;
        mT0     = 0;
        mLoaded = 1'b0;
        mReady  = 1'b1;
        mNumber = '0;
        eSeg    = '0;
        eDig    = '0;
        eFrame  = 1'b0;
    endtask

    task automatic modelStep(input logic v, input logic [DW-1:0] n, input logic e);
        bit acc;
        int k, p, idx;
        cyc++;
        acc    = v && mReady;
        eSeg   = '0;
        eDig   = '0;
        eFrame = 1'b0;
        if (mPhase == 2 && e && !acc) begin
            k      = cyc - mT0;
            p      = k - 1;
            idx    = 3 - ((p / DIV) % 4);
            eSeg   = expSeg(mNumber, idx);
            eDig   = ((p % DIV) < BLANK) ? 4'b0000 : (4'b0001 << idx);
            eFrame = ((k % (4 * DIV)) == 0);
        end
        if (acc) begin
            mNumber = n;
            mLoaded = 1'b1;
            mPhase  = 1;
        end else if (mPhase == 1) begin
            if (e) begin
                mPhase = 2;
                mT0    = cyc;
            end else begin
                mPhase = 0;
            end
        end else if (mPhase == 0) begin
            if (mLoaded && e) begin
                mPhase = 2;
                mT0    = cyc;
            end
        end else if (!e) begin
            mPhase = 0;
        end
        mReady = (mPhase != 1);
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("digit_en",   {28'd0, digit_en},          {28'd0, eDig});
        checkValue("seg_out",    {25'd0, seg_out},           {25'd0, eSeg});
        checkValue("frame_done", {31'd0, frame_done},        {31'd0, eFrame});
        checkValue("load_ready", {31'd0, load_if.load_ready}, {31'd0, mReady});
        checkValue("dec_number", {24'd0, dec_number},        {24'd0, mNumber});
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] n, input logic e);
        load_if.load_valid  = v;
        load_if.load_number = n;
        disp_en             = e;
        @(posedge clk);
        modelStep(v, n, e);
        #1;
        checkOutput();
    endtask

    // Runs one frame plus margin and records what each digit showed.
    task automatic captureFrame(output logic [3:0][6:0] segs, output logic [3:0] seen);
        segs = '0;
        seen = '0;
        for (int i = 0; i < 4 * DIV + 2; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            for (int b = 0; b < 4; b++) begin
                if (digit_en == (4'b0001 << b)) begin
                    segs[b] = seg_out;
                    seen[b] = 1'b1;
                end
            end
        end
    endtask

    task automatic waitDigit(input logic [3:0] target, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (digit_en == target) found = 1'b1;
        end
        checkValue({name, "_reached"}, {31'd0, found}, 32'd1);
    endtask

    task automatic checkFrame(input string name, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        logic [3:0][6:0] segs;
        logic [3:0]      seen;
        captureFrame(segs, seen);
        checkValue({name, "_seen"},  {28'd0, seen},    32'hF);
        checkValue({name, "_sign"},  {25'd0, segs[3]}, {25'd0, s3});
        checkValue({name, "_hund"},  {25'd0, segs[2]}, {25'd0, s2});
        checkValue({name, "_tens"},  {25'd0, segs[1]}, {25'd0, s1});
        checkValue({name, "_units"}, {25'd0, segs[0]}, {25'd0, s0});
    endtask

    typedef struct {
        logic [DW-1:0] number;
        logic [6:0]    segSign;
        logic [6:0]    segHund;
        logic [6:0]    segTens;
        logic [6:0]    segUnits;
    } vec_t;

    vec_t vecs[6];

    // Main test sequence.
    initial begin
        int pulses;
        vecs[0] = '{8'h80, S_MI, S_1, S_2, S_8};
        vecs[1] = '{8'd5,  S_BL, LZ ? S_BL : S_0, LZ ? S_BL : S_0, S_5};
        vecs[2] = '{8'd42, S_BL, LZ ? S_BL : S_0, S_4, S_2};
        vecs[3] = '{8'hFF, S_MI, LZ ? S_BL : S_0, LZ ? S_BL : S_0, S_1};
        vecs[4] = '{8'd127, S_BL, S_1, S_2, S_7};
        vecs[5] = '{8'd105, S_BL, S_1, S_0, S_5};

        load_if.load_valid  = 1'b0;
        load_if.load_number = '0;
        modelReset();
        #12;
        checkOutput();
        #3 rst_n = 1'b1;

        // Nothing loaded: stays blank with the display enabled.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vecs[i].number, 1'b1);
            checkFrame($sformatf("vec%0d", i), vecs[i].segSign, vecs[i].segHund,
                       vecs[i].segTens, vecs[i].segUnits);
        end

        // Frame pulse rate: load then 64 cycles gives pulses at 16, 32, 48 after scan start.
        applyStimulus(1'b1, 8'h80, 1'b1);
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (frame_done) pulses++;
        end
        checkValue("frame_pulses", pulses, 32'd3);

        // Load mid-scan in the tens slot.
        waitDigit(4'b0010, "tens_slot");
        applyStimulus(1'b1, 8'd42, 1'b1);
        checkValue("midscan_ready", {31'd0, load_if.load_ready}, 32'd0);
        checkFrame("midscan", S_BL, LZ ? S_BL : S_0, S_4, S_2);

        // Display disabled in the hundreds slot, then re-enabled.
        waitDigit(4'b0100, "hund_slot");
        applyStimulus(1'b0, '0, 1'b0);
        checkValue("disable_blank", {28'd0, digit_en}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                applyStimulus(1'b0, '0, 1'b1);
                if (digit_en != 4'b0000) found = 1'b1;
            end
            checkValue("reenable_first", {28'd0, digit_en}, 32'b1000);
        end
        checkFrame("reenable", S_BL, LZ ? S_BL : S_0, S_4, S_2);

        // Load and disp_en drop together: number captured, display stays blank.
        applyStimulus(1'b1, 8'd77, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0);
        checkValue("load_while_off_num", {24'd0, dec_number}, 32'd77);
        checkValue("load_while_off_dig", {28'd0, digit_en}, 32'd0);

        // load_valid held across the SETTLE cycle: last accepted value wins.
        applyStimulus(1'b1, 8'd127, 1'b1);
        applyStimulus(1'b1, 8'd127, 1'b1);
        applyStimulus(1'b1, 8'hFF, 1'b1);
        checkFrame("held_valid", S_MI, LZ ? S_BL : S_0, LZ ? S_BL : S_0, S_1);

        // Asynchronous reset away from the clock edge.
        waitDigit(4'b0010, "pre_reset");
        load_if.load_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1);

        // Random traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0), DW'($urandom),
                          ($urandom_range(0, 15) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
